heap_ctrl: RTL and testbench
============================

# heap_ctrl

Frame sequencer for the `heap` sorter.
- Accepts a ready/valid input stream framed by `s_last`.
- Pulses `init` on the heap, feeds up to its capacity of keys through `din`/`en`, then pulses `flush`.
- Collects the sorted `dout`/`valid` burst and re-frames it as an output stream with `m_last`.
- Sits between the feature-score producer and the downstream selector, so neither has to know heap timing.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of one element (key in LSBs).
- `KEY_WIDTH`, 4, key width; passed through to the heap.
- `NLEVELS`, 3, heap levels; capacity `CAP = 2**NLEVELS - 1` (7).
- `INIT_WAIT`, 4, cycles after the `init` pulse before loading starts (≥1).
- `DRAIN_TIMEOUT`, 64, idle cycles allowed in DRAIN without a heap `valid`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `start` in 1: begin one frame; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on return to IDLE.
- `overflow` out 1: sticky per frame; set when an element beyond CAP was discarded.
- `timeout_err` out 1: sticky per frame; set when DRAIN exits by timeout.
- `s_data` in DATA_WIDTH: input element.
- `s_valid` in 1: input element valid.
- `s_last` in 1: last element of the frame.
- `s_ready` out 1: high in LOAD and DISCARD only.
- `heap_din` out DATA_WIDTH: heap `din`.
- `heap_en` out 1: heap `en`.
- `heap_init` out 1: heap `init`.
- `heap_flush` out 1: heap `flush`.
- `heap_dout` in DATA_WIDTH: heap `dout`.
- `heap_valid` in 1: heap `valid`.
- `m_data` out DATA_WIDTH: sorted element.
- `m_valid` out 1: output element valid; there is no backpressure.
- `m_last` out 1: marks the final sorted element.
- `loaded_cnt` out NLEVELS: number of elements loaded in the current frame.

## Operation
States and transitions:
- IDLE → INIT on `start`. Entering INIT clears `loaded_cnt`, `overflow` and `timeout_err`.
- INIT: `heap_init`=1 for exactly 1 cycle, then WAIT.
- WAIT: count INIT_WAIT cycles, then LOAD.
- LOAD: each accepted element (`s_valid & s_ready`) is registered to `heap_din` with `heap_en`=1 for one cycle, and `loaded_cnt` increments.
  - Accepted with `s_last` → FLUSH.
  - Accepted element is the CAP-th, without `s_last` → DISCARD.
  - Accepted element is the CAP-th, with `s_last` → FLUSH; no overflow.
- DISCARD: consumes elements with `heap_en`=0 and sets `overflow`; the element carrying `s_last` → FLUSH.
- FLUSH: `heap_flush`=1 for 1 cycle, then DRAIN.
- DRAIN: each `heap_valid` produces one output element and increments `out_cnt`. When `out_cnt` reaches `loaded_cnt`, that element carries `m_last` → IDLE with `done`. Any further `heap_valid` is ignored.
- Timeout: in DRAIN, DRAIN_TIMEOUT consecutive cycles without `heap_valid` → IDLE, `done`=1, `timeout_err`=1, and no `m_last`.

Boundary rules:
- `start` while busy is ignored.
- `heap_valid` outside DRAIN is ignored and never reaches `m_valid`.
- A zero-length frame cannot occur, because `s_last` always rides on an element.
- Reset mid-frame: return to IDLE immediately. The heap is re-initialised by the next INIT.

## Timing
- Reset values: every output is 0, including `m_data`, `heap_din` and `loaded_cnt`.
- Load latency: element accepted at cycle t appears on `heap_din` with `heap_en` at cycle t+1.
- Output latency: `heap_valid` at cycle t gives `m_valid` at t+1, with `m_data` = `heap_dout` sampled at t.
- `heap_flush` is asserted one cycle after the final accepted element.
- `done` is asserted in the cycle after `m_last`, which is the first IDLE cycle.
- Minimum restart: a new `start` is accepted one cycle after `done`.
- All heap-side outputs are registered.

## Structure
- Package `heap_pkg` holds:
  - the state enum (IDLE, INIT, WAIT, LOAD, DISCARD, FLUSH, DRAIN);
  - a `heap_cap(NLEVELS)` function;
  - a `cnt_w(x)` function used to size the counters.
- `out_cnt` and the timeout counter are inline.
- One sub-module, `heap_ctrl_fsm`, holds the state register and next-state logic. The datapath registers stay in the top.

## Test plan
- Frame of 5 keys {3,9,1,7,4} with `s_last` on 4: expect `heap_en` 5 times, one `heap_flush`, 5 `m_valid` with `m_last` on the 5th, then `done`; `overflow`=0.
- Frame of 10 keys: expect 7 loaded, 3 discarded, `overflow`=1, 7 outputs, `s_ready` held through `s_last`.
- Exactly 7 keys with `s_last` on the 7th: expect FLUSH directly, `overflow`=0.
- Heap model that stops after 2 `valid`s of 5: expect `timeout_err`=1 and `done` 64 cycles after the last `valid`; no `m_last`.
- `rstn` dropped mid-LOAD, then `start` again: expect all outputs 0, a fresh `heap_init` pulse, and `loaded_cnt` restarting at 0.
- `start` pulsed during DRAIN, plus a spurious `heap_valid` in IDLE: expect no effect and no `m_valid`.

Source files
------------

// File: rtl/heap_pkg.sv
// rtl/heap_pkg.sv - shared types and sizing helpers for the heap frame sequencer
// Purpose: state encoding for heap_ctrl_fsm plus capacity and counter-width helpers.
// Contents: state_t, heap_cap(), cnt_w().
package heap_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    WAIT    = 3'd2,
    LOAD    = 3'd3,
    DISCARD = 3'd4,
    FLUSH   = 3'd5,
    DRAIN   = 3'd6
  } state_t;

  // Number of keys a heap of nlevels levels can hold.
  function automatic int heap_cap(input int nlevels);
    return (1 << nlevels) - 1;
  endfunction

  // Bits needed to hold any value 0..x.
  function automatic int cnt_w(input int x);
    return (x < 1) ? 1 : $clog2(x + 1);
  endfunction

endpackage

// File: rtl/heap_ctrl_if.sv
// rtl/heap_ctrl_if.sv - stream and heap-side signal bundle for heap_ctrl
// Purpose: groups the input stream, heap handshake and output stream.
// Modports: master = heap_ctrl side, slave = producer/heap/consumer side.
interface heap_ctrl_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_ready;

  logic [DATA_WIDTH-1:0] heap_din;
  logic                  heap_en;
  logic                  heap_init;
  logic                  heap_flush;
  logic [DATA_WIDTH-1:0] heap_dout;
  logic                  heap_valid;

  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_last;

  modport master (
    input  s_data, s_valid, s_last,
    output s_ready,
    output heap_din, heap_en, heap_init, heap_flush,
    input  heap_dout, heap_valid,
    output m_data, m_valid, m_last
  );

  modport slave (
    output s_data, s_valid, s_last,
    input  s_ready,
    input  heap_din, heap_en, heap_init, heap_flush,
    output heap_dout, heap_valid,
    input  m_data, m_valid, m_last
  );

endinterface

// File: rtl/heap_ctrl_fsm.sv
// rtl/heap_ctrl_fsm.sv - frame state machine for heap_ctrl
// Purpose: state register and next-state logic; all datapath lives in the top.
// Ports: clk/rstn; i_* event qualifiers computed by the top; o_state current
//        state, o_next next state (used by the top for registered pulses).
module heap_ctrl_fsm
  import heap_pkg::*;
(
  input  logic   clk,
  input  logic   rstn,
  input  logic   i_start,
  input  logic   i_accept,
  input  logic   i_last,
  input  logic   i_at_cap,
  input  logic   i_wait_done,
  input  logic   i_drain_done,
  input  logic   i_drain_timeout,
  output state_t o_state,
  output state_t o_next
);

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (i_start) w_next = INIT;
      INIT:    w_next = WAIT;
      WAIT:    if (i_wait_done) w_next = LOAD;
      LOAD: begin
        // s_last wins over capacity: a full frame ending exactly at CAP is not an overflow.
        if (i_accept && i_last)        w_next = FLUSH;
        else if (i_accept && i_at_cap) w_next = DISCARD;
      end
      DISCARD: if (i_accept && i_last) w_next = FLUSH;
      FLUSH:   w_next = DRAIN;
      DRAIN:   if (i_drain_done || i_drain_timeout) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign o_state = r_state;
  assign o_next  = w_next;

endmodule

// File: rtl/heap_ctrl.sv
// rtl/heap_ctrl.sv - frame sequencer that loads, flushes and drains the heap sorter
// Purpose: accepts a framed stream, feeds up to CAP keys to the heap, re-frames the
//          sorted burst with m_last, flags overflow and drain timeout per frame.
// Ports: clk, rstn (async active-low); start; busy/done/overflow/timeout_err status;
//        loaded_cnt; bus (s_* input stream, heap_* heap handshake, m_* output stream).
module heap_ctrl
  import heap_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int KEY_WIDTH     = 4,
  parameter int NLEVELS       = 3,
  parameter int INIT_WAIT     = 4,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic               timeout_err,
  output logic [NLEVELS-1:0] loaded_cnt,
  heap_ctrl_if.master        bus
);

  localparam int CAP   = heap_cap(NLEVELS);
  localparam int OUT_W = cnt_w(CAP);
  // One timer serves both the WAIT countdown and the DRAIN idle watchdog.
  localparam int TMR_W = cnt_w((DRAIN_TIMEOUT > INIT_WAIT) ? DRAIN_TIMEOUT : INIT_WAIT);

  if (KEY_WIDTH > DATA_WIDTH) begin : g_key_check
    $error("heap_ctrl: KEY_WIDTH must not exceed DATA_WIDTH");
  end

  state_t                  w_state;
  state_t                  w_next;
  logic                    w_s_ready;
  logic                    w_accept;
  logic                    w_at_cap;
  logic                    w_wait_done;
  logic                    w_drain_take;
  logic                    w_drain_timeout;

  logic [NLEVELS-1:0]      r_loaded_cnt;
  logic [OUT_W-1:0]        r_out_cnt;
  logic [TMR_W-1:0]        r_tmr;
  logic                    r_overflow;
  logic                    r_timeout_err;
  logic                    r_done;
  logic [DATA_WIDTH-1:0]   r_heap_din;
  logic                    r_heap_en;
  logic                    r_heap_init;
  logic                    r_heap_flush;
  logic [DATA_WIDTH-1:0]   r_m_data;
  logic                    r_m_valid;
  logic                    r_m_last;

  assign w_s_ready   = (w_state == LOAD) || (w_state == DISCARD);
  assign w_accept    = bus.s_valid && w_s_ready;
  assign w_at_cap    = (r_loaded_cnt == NLEVELS'(CAP - 1));
  assign w_wait_done = (r_tmr == TMR_W'(INIT_WAIT - 1));
  // Once m_last has been issued the frame is closed; stray heap valids are dropped.
  assign w_drain_take    = (w_state == DRAIN) && bus.heap_valid && !r_m_last;
  assign w_drain_timeout = (w_state == DRAIN) && !bus.heap_valid && !r_m_last &&
                           (r_tmr == TMR_W'(DRAIN_TIMEOUT - 1));

  heap_ctrl_fsm u_fsm (
    .clk             (clk),
    .rstn            (rstn),
    .i_start         (start),
    .i_accept        (w_accept),
    .i_last          (bus.s_last),
    .i_at_cap        (w_at_cap),
    .i_wait_done     (w_wait_done),
    .i_drain_done    (r_m_last),
    .i_drain_timeout (w_drain_timeout),
    .o_state         (w_state),
    .o_next          (w_next)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_loaded_cnt  <= '0;
      r_out_cnt     <= '0;
      r_tmr         <= '0;
      r_overflow    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_done        <= 1'b0;
      r_heap_din    <= '0;
      r_heap_en     <= 1'b0;
      r_heap_init   <= 1'b0;
      r_heap_flush  <= 1'b0;
      r_m_data      <= '0;
      r_m_valid     <= 1'b0;
      r_m_last      <= 1'b0;
    end else begin
      // INIT and FLUSH last exactly one cycle, so the pulses follow the next state.
      r_heap_init  <= (w_next == INIT);
      r_heap_flush <= (w_next == FLUSH);
      r_heap_en    <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_last     <= 1'b0;
      r_done       <= (w_state == DRAIN) && (w_next == IDLE);

      if (w_state == IDLE && start) begin
        r_loaded_cnt  <= '0;
        r_out_cnt     <= '0;
        r_overflow    <= 1'b0;
        r_timeout_err <= 1'b0;
      end

      if (w_next != w_state)       r_tmr <= '0;
      else if (w_state == WAIT)    r_tmr <= r_tmr + TMR_W'(1);
      else if (w_state == DRAIN)   r_tmr <= bus.heap_valid ? '0 : r_tmr + TMR_W'(1);

      if (w_state == LOAD && w_accept) begin
        r_heap_din   <= bus.s_data;
        r_heap_en    <= 1'b1;
        r_loaded_cnt <= r_loaded_cnt + NLEVELS'(1);
      end

      if (w_state == DISCARD && w_accept) r_overflow <= 1'b1;

      if (w_drain_take) begin
        r_m_valid <= 1'b1;
        r_m_data  <= bus.heap_dout;
        r_out_cnt <= r_out_cnt + OUT_W'(1);
        r_m_last  <= ((r_out_cnt + OUT_W'(1)) == OUT_W'(r_loaded_cnt));
      end

      if (w_drain_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign busy           = (w_state != IDLE);
  assign done           = r_done;
  assign overflow       = r_overflow;
  assign timeout_err    = r_timeout_err;
  assign loaded_cnt     = r_loaded_cnt;
  assign bus.s_ready    = w_s_ready;
  assign bus.heap_din   = r_heap_din;
  assign bus.heap_en    = r_heap_en;
  assign bus.heap_init  = r_heap_init;
  assign bus.heap_flush = r_heap_flush;
  assign bus.m_data     = r_m_data;
  assign bus.m_valid    = r_m_valid;
  assign bus.m_last     = r_m_last;

endmodule

// File: tb/tb_heap_ctrl.sv
// tb/tb_heap_ctrl.sv - directed self-checking bench for heap_ctrl
module tb_heap_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, overflow, timeout_err;
  logic [2:0] loaded_cnt;

  heap_ctrl_if #(.DATA_WIDTH(8)) bus ();

  heap_ctrl #(
    .DATA_WIDTH(8), .KEY_WIDTH(4), .NLEVELS(3), .INIT_WAIT(4), .DRAIN_TIMEOUT(64)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
    .overflow(overflow), .timeout_err(timeout_err), .loaded_cnt(loaded_cnt), .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_en = 0, n_flush = 0, n_init = 0, n_mv = 0, n_ml = 0, n_done = 0;
  int b_en, b_flush, b_init, b_mv, b_ml, b_done;
  int kq[$];
  int vq[$];

  always @(negedge clk) begin
    if (bus.heap_en)    n_en++;
    if (bus.heap_flush) n_flush++;
    if (bus.heap_init)  n_init++;
    if (bus.m_valid)    n_mv++;
    if (bus.m_last)     n_ml++;
    if (done)           n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_en = n_en; b_flush = n_flush; b_init = n_init;
    b_mv = n_mv; b_ml = n_ml; b_done = n_done;
  endtask

  // Start a frame, confirm the init pulse, then wait for LOAD (INIT + 4 WAIT cycles).
  task automatic do_start();
    int k;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("init_pulse", bus.heap_init, 1);
    chk("busy_init", busy, 1);
    chk("loaded_clr", loaded_cnt, 0);
    k = 0;
    while (!bus.s_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("load_delay", k, 5);
  endtask

  // Drive kq back-to-back; the first 7 keys must reach the heap one cycle later.
  task automatic send(input bit mark_last);
    for (int i = 0; i < kq.size(); i++) begin
      bus.s_data  = kq[i][7:0];
      bus.s_valid = 1'b1;
      bus.s_last  = mark_last && (i == kq.size() - 1);
      chk("s_ready", bus.s_ready, 1);
      @(negedge clk);
      chk("heap_en", bus.heap_en, (i < 7) ? 1 : 0);
      if (i < 7) chk("heap_din", bus.heap_din, kq[i]);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (mark_last) begin
      chk("heap_flush", bus.heap_flush, 1);
      chk("s_ready_off", bus.s_ready, 0);
    end
  endtask

  // Play the heap's sorted burst from vq, starting in the first DRAIN cycle.
  task automatic emit(input bit expect_last, input bit poke_start);
    @(negedge clk);
    for (int j = 0; j < vq.size(); j++) begin
      bus.heap_valid = 1'b1;
      bus.heap_dout  = vq[j][7:0];
      if (poke_start && j == 0) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("m_valid", bus.m_valid, 1);
      chk("m_data", bus.m_data, vq[j]);
      chk("m_last", bus.m_last, (expect_last && j == vq.size() - 1) ? 1 : 0);
    end
    bus.heap_valid = 1'b0;
  endtask

  task automatic expect_done();
    @(negedge clk);
    chk("done", done, 1);
    chk("busy_done", busy, 0);
    chk("m_valid_after", bus.m_valid, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_tmo"}, timeout_err, 0);
    chk({tag, "_loaded"}, loaded_cnt, 0);
    chk({tag, "_s_ready"}, bus.s_ready, 0);
    chk({tag, "_heap_din"}, bus.heap_din, 0);
    chk({tag, "_heap_en"}, bus.heap_en, 0);
    chk({tag, "_heap_init"}, bus.heap_init, 0);
    chk({tag, "_heap_flush"}, bus.heap_flush, 0);
    chk({tag, "_m_data"}, bus.m_data, 0);
    chk({tag, "_m_valid"}, bus.m_valid, 0);
    chk({tag, "_m_last"}, bus.m_last, 0);
  endtask

  initial begin
    int k;
    bus.s_data = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
    bus.heap_dout = '0; bus.heap_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    rstn = 1'b1;
    @(negedge clk);

    // Frame of 5 keys; start poked during DRAIN must be ignored
    snap();
    kq = '{3, 9, 1, 7, 4};
    vq = '{1, 3, 4, 7, 9};
    do_start();
    send(1'b1);
    emit(1'b1, 1'b1);
    expect_done();
    chk("a_en_cnt", n_en - b_en, 5);
    chk("a_flush_cnt", n_flush - b_flush, 1);
    chk("a_mv_cnt", n_mv - b_mv, 5);
    chk("a_ml_cnt", n_ml - b_ml, 1);
    chk("a_done_cnt", n_done - b_done, 1);
    chk("a_loaded", loaded_cnt, 5);
    chk("a_overflow", overflow, 0);
    chk("a_timeout", timeout_err, 0);

    // Spurious heap_valid while IDLE must not reach m_valid or restart anything
    snap();
    bus.heap_valid = 1'b1; bus.heap_dout = 8'd77;
    repeat (2) @(negedge clk);
    bus.heap_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_mv_cnt", n_mv - b_mv, 0);
    chk("idle_busy", busy, 0);
    chk("idle_init_cnt", n_init - b_init, 0);

    // Frame of 10 keys: 7 loaded, 3 discarded
    snap();
    kq = '{12, 5, 200, 33, 7, 90, 1, 64, 8, 2};
    vq = '{1, 5, 7, 12, 33, 90, 200};
    do_start();
    send(1'b1);
    chk("b_overflow", overflow, 1);
    chk("b_loaded", loaded_cnt, 7);
    emit(1'b1, 1'b0);
    expect_done();
    chk("b_en_cnt", n_en - b_en, 7);
    chk("b_mv_cnt", n_mv - b_mv, 7);
    chk("b_ml_cnt", n_ml - b_ml, 1);

    // Exactly CAP keys with s_last on the 7th: straight to FLUSH, no overflow
    snap();
    kq = '{6, 6, 0, 255, 128, 17, 42};
    vq = '{0, 6, 6, 17, 42, 128, 255};
    do_start();
    send(1'b1);
    chk("c_overflow", overflow, 0);
    chk("c_loaded", loaded_cnt, 7);
    emit(1'b1, 1'b0);
    expect_done();
    chk("c_en_cnt", n_en - b_en, 7);

    // Heap stalls after 2 of 5 valids: timeout 64 cycles after the last m_valid
    snap();
    kq = '{3, 9, 1, 7, 4};
    vq = '{1, 3};
    do_start();
    send(1'b1);
    emit(1'b0, 1'b0);
    k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("d_timeout_delay", k, 64);
    chk("d_timeout_err", timeout_err, 1);
    chk("d_busy", busy, 0);
    @(negedge clk);
    chk("d_ml_cnt", n_ml - b_ml, 0);
    chk("d_mv_cnt", n_mv - b_mv, 2);
    chk("d_overflow", overflow, 0);

    // Reset in the middle of LOAD, then a clean frame
    snap();
    kq = '{10, 11};
    do_start();
    send(1'b0);
    chk("e_loaded_mid", loaded_cnt, 2);
    rstn = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk) rstn = 1'b1;
    snap();
    kq = '{5, 2, 8};
    vq = '{2, 5, 8};
    do_start();
    send(1'b1);
    emit(1'b1, 1'b0);
    expect_done();
    chk("e_init_cnt", n_init - b_init, 1);
    chk("e_loaded", loaded_cnt, 3);
    chk("e_ml_cnt", n_ml - b_ml, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
